// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder controller.
package serial_adder_pkg;
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/Full_adder.sv
// Single-bit full adder used as the bit-serial datapath.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencing controller: feeds operands LSB-first through one Full_adder
// over WIDTH cycles and publishes a registered sum/carry with a done pulse.
module serial_add_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  // Bit 0 of the partial-sum shift register is always discarded before the
  // final capture, so only the upper WIDTH-1 bits are kept.
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_full;
  logic [CW-1:0]    bit_cnt;
  logic             carry;
  logic             fa_s, fa_c;
  logic             load, step, fin, last;

  Full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign sum_full = {fa_s, sum_sr};
  assign last     = (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // abort wins over the final-bit exit and processes no bit
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            fin       = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      bit_cnt <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      sum_sr  <= '0;
      bit_cnt <= '0;
      carry   <= cin;
    end else if (step) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr  <= sum_full[WIDTH-1:1];
      bit_cnt <= bit_cnt + CW'(1);
      carry   <= fa_c;
      if (fin) begin
        sum  <= sum_full;
        cout <= fa_c;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against an arithmetic reference.
module tb_serial_add_ctrl;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit addition.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    full     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    model(x, y, c);
    @(negedge clk);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    start = 1'b0;
  endtask

  // Walks the remaining WIDTH-1 RUN cycles, the done cycle, and back to IDLE.
  task automatic finish_op(input bit scramble);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      chk("run_busy_done", {62'd0, busy, done}, 64'h2);
      if (scramble) begin
        a = $urandom; b = $urandom; cin = 1'($urandom);
      end
    end
    @(negedge clk);
    chk("done_pulse", {62'd0, busy, done}, 64'h1);
    chk("sum", {32'd0, sum}, {32'd0, exp_sum});
    chk("cout", {63'd0, cout}, {63'd0, exp_cout});
    @(negedge clk);
    chk("idle_after_done", {62'd0, busy, done}, 64'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {30'd0, busy, done, cout, sum}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(32'h1, 32'h1, 1'b0);           finish_op(0);
    start_op(32'hFFFFFFFF, 32'h1, 1'b0);    finish_op(0);
    start_op(32'h0, 32'h0, 1'b1);           finish_op(0);
    start_op(32'h80000000, 32'h80000000, 1'b1); finish_op(0);
    start_op(32'h12345678, 32'h9ABCDEF0, 1'b0); finish_op(0);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); finish_op(0);

    for (int k = 0; k < 6; k++) begin
      start_op($urandom, $urandom, 1'($urandom));
      finish_op(0);
    end

    // start held high through the whole op while operands keep changing
    start_op($urandom, $urandom, 1'($urandom));
    start = 1'b1;
    finish_op(1);
    start_op(a, b, cin);
    finish_op(0);

    // abort after bit 10
    start_op(32'h1, 32'h1, 1'b0); finish_op(0);
    start_op($urandom, $urandom, 1'b1);
    for (int i = 1; i <= 10; i++) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    @(negedge clk);
    chk("abort_idle", {62'd0, busy, done}, 64'h0);
    chk("abort_sum_kept", {31'd0, cout, sum}, 64'h2);
    abort = 1'b0;
    model(a, b, cin);
    @(negedge clk);
    chk("restart_after_abort", {63'd0, busy}, 64'd1);
    start = 1'b0;
    finish_op(0);

    // reset mid-operation at bit 16, with start/abort asserted
    start_op($urandom, $urandom, 1'($urandom));
    for (int i = 1; i <= 16; i++) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("midop_reset", {30'd0, busy, done, cout, sum}, 64'd0);
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {62'd0, busy, done}, 64'h0);
    end
    start_op($urandom, $urandom, 1'($urandom));
    finish_op(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
